cache_line_buffer: RTL
======================

# cache_line_buffer

Single-line staging buffer between the L1 instruction/data caches and main memory, driven directly by the cache controller's `we_cl`, `next_cl`, `sel_cl` and `clr` strobes. It performs three jobs:
- collects a line word-by-word from main memory or from a dirty dmem victim line;
- replays the line word-by-word into imem, dmem or main memory;
- reports `full_cl` back to the controller, which uses it to sequence its refill/writeback states.

## Interface
Parameters:
- `WORDS_PER_LINE`, 4: words per cache line; power of two, ≥2.
- `DATA_WIDTH`, 32: word width in bits.
- `IDX_W`, $clog2(WORDS_PER_LINE): word-offset width (derived, not overridden).

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `clr`  in  1  synchronous clear of index, storage and flags.
- `we_cl`  in  1  capture enable; the word is stored only when `next_cl` is also 1.
- `next_cl`  in  1  advance word index (capture or replay step).
- `sel_cl`  in  2  capture source: 00 = `mm_rdata` (imem refill), 01 = `mm_rdata` (dmem refill), 10 = `dmem_rdata` (victim writeback), 11 = illegal.
- `mm_rdata`  in  DATA_WIDTH  main-memory read word.
- `dmem_rdata`  in  DATA_WIDTH  dmem victim word at offset `word_idx`.
- `word_idx`  out  IDX_W  current word offset; addresses dmem victim reads, L1 fill writes and mm reads/writes.
- `word_out`  out  DATA_WIDTH  stored word at `word_idx` (combinational read).
- `full_cl`  out  1  `word_idx == WORDS_PER_LINE-1`.
- `line_valid`  out  1  all words captured since the last clear or replay completion.
- `src_dmem`  out  1  registered: the last completed capture came from `sel_cl`=10 (the line is destined for mm).
- `sel_err`  out  1  sticky: a capture was attempted with `sel_cl`=11.

## Operation
- Storage: WORDS_PER_LINE × DATA_WIDTH register array `buf`, plus index counter `idx` (IDX_W bits) and flags `line_valid`, `src_dmem`, `sel_err`.
- Priority each edge: `reset` > `clr` > capture/advance.
- Reset or `clr`: `idx`←0, all `buf` words←0, `line_valid`←0, `src_dmem`←0, `sel_err`←0.
- Capture, when `we_cl & next_cl` and `sel_cl`≠11:
  - `buf[idx]` ← `mm_rdata` for sel 00/01, or `dmem_rdata` for sel 10;
  - `idx` ← `idx+1` mod WORDS_PER_LINE;
  - if `idx == WORDS_PER_LINE-1`: `line_valid`←1 and `src_dmem`←(`sel_cl`==10).
- Illegal capture, when `we_cl & next_cl & sel_cl`==11: no write, `idx` unchanged, `sel_err`←1 (held until reset/`clr`).
- Replay, when `next_cl & ~we_cl`: `buf` unchanged, `idx` ← `idx+1` mod N. If `idx == N-1`, `line_valid`←0 (line consumed).
- Hold, when `next_cl`=0: no change. `we_cl` alone has no effect; this covers `mem_valid_mm` stalls.
- Wrap: `idx` rolls N-1→0 without a gap, so a capture pass followed immediately by a replay pass starts the replay at offset 0.
- `word_out` = `buf[idx]`, purely combinational. A word written on edge k is visible at that index from after edge k.
- Arithmetic: `idx` increments modulo 2^IDX_W. No saturation.

## Timing
- Reset values: `word_idx`=0, `word_out`=0, `full_cl`=0, `line_valid`=0, `src_dmem`=0, `sel_err`=0.
- `full_cl` and `word_out` are combinational from registered `idx`/`buf`. `full_cl` is valid in the same cycle in which the controller samples it, so the controller leaves its fetch state on the edge that captures the last word.
- Capture latency: one edge per word. A full line with continuous `next_cl` takes WORDS_PER_LINE cycles; `line_valid` rises on the edge after the last capture.
- Replay latency: `word_out` for offset i is presented in the cycle `idx`==i. N cycles per line.
- Capture after a stalled cycle (`next_cl`=0) resumes at the same `idx`; no word is dropped or duplicated.
- `clr` during a capture or replay aborts it: `idx`=0 and `line_valid`=0 on the next cycle, regardless of `next_cl`.
- `reset` mid-operation behaves identically to `clr`.
- `sel_cl` change mid-line is permitted. Each word uses the `sel_cl` of its own capture cycle; `src_dmem` reflects only the final word's source.

## Test plan
- Reset, then 4 captures with `sel_cl`=00 and `mm_rdata` = 0xA0,0xA1,0xA2,0xA3 -> `full_cl`=1 only in the 4th cycle; then `idx`=0, `line_valid`=1, `src_dmem`=0. Replay with `next_cl`=1, `we_cl`=0 -> `word_out` = A0,A1,A2,A3 on offsets 0..3, then `line_valid`=0.
- Capture with `next_cl` toggling 1,0,0,1,1,0,1 (mem stall) -> exactly 4 words stored, `idx` stalls on zero cycles, no duplicates.
- Writeback: `sel_cl`=10 with `dmem_rdata` = 0xD0+`word_idx` -> `buf`={D0..D3}, `src_dmem`=1. Replay (FILL_MM pattern, `next_cl`=`mem_valid_mm` random) -> `word_out` matches in order.
- `clr` asserted after 2 of 4 captures -> next cycle `idx`=0, `buf` all 0, `full_cl`=0, `line_valid`=0.
- `we_cl`=`next_cl`=1 with `sel_cl`=11 -> `sel_err`=1, `idx` unchanged, `buf` unchanged; `sel_err` stays 1 until `clr`.
- Back-to-back: capture pass followed immediately by a replay pass, with `WORDS_PER_LINE`=8 -> `full_cl` pulses at `idx`=7 in each pass, and `idx` wraps 7→0 with no idle cycle.

Source files
------------

// File: rtl/cache_line_buffer_if.sv
// rtl/cache_line_buffer_if.sv - controller-facing strobes and status of the cache line buffer
interface cache_line_buffer_if #(
    parameter int WORDS_PER_LINE = 4,
    parameter int DATA_WIDTH     = 32
);
    localparam int IDX_W = $clog2(WORDS_PER_LINE);

    logic                  clr;
    logic                  we_cl;
    logic                  next_cl;
    logic [1:0]            sel_cl;
    logic [DATA_WIDTH-1:0] mm_rdata;
    logic [DATA_WIDTH-1:0] dmem_rdata;
    logic [IDX_W-1:0]      word_idx;
    logic [DATA_WIDTH-1:0] word_out;
    logic                  full_cl;
    logic                  line_valid;
    logic                  src_dmem;
    logic                  sel_err;

    modport master (
        output clr, we_cl, next_cl, sel_cl, mm_rdata, dmem_rdata,
        input  word_idx, word_out, full_cl, line_valid, src_dmem, sel_err
    );

    modport slave (
        input  clr, we_cl, next_cl, sel_cl, mm_rdata, dmem_rdata,
        output word_idx, word_out, full_cl, line_valid, src_dmem, sel_err
    );
endinterface

// File: rtl/cache_line_buffer.sv
// rtl/cache_line_buffer.sv - single-line staging buffer between L1 caches and main memory
module cache_line_buffer #(
    parameter int WORDS_PER_LINE = 4,
    parameter int DATA_WIDTH     = 32,
    localparam int IDX_W         = $clog2(WORDS_PER_LINE)
) (
    input logic              clk,
    input logic              reset,
    cache_line_buffer_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_LINE - 1);
    localparam logic [1:0]       SEL_DMEM = 2'b10;
    localparam logic [1:0]       SEL_BAD  = 2'b11;

    logic [DATA_WIDTH-1:0] line_buf [WORDS_PER_LINE];
    logic [IDX_W-1:0]      idx_q;
    logic                  line_valid_q;
    logic                  src_dmem_q;
    logic                  sel_err_q;

    logic                  at_last;
    logic                  do_capture;
    logic                  do_illegal;
    logic                  do_replay;
    logic [DATA_WIDTH-1:0] capture_word;

    always_comb begin
        at_last      = (idx_q == LAST_IDX);
        do_capture   = bus.we_cl & bus.next_cl & (bus.sel_cl != SEL_BAD);
        do_illegal   = bus.we_cl & bus.next_cl & (bus.sel_cl == SEL_BAD);
        do_replay    = bus.next_cl & ~bus.we_cl;
        // sel 00/01 both refill from main memory; only 10 takes the dmem victim
        capture_word = bus.sel_cl[1] ? bus.dmem_rdata : bus.mm_rdata;
    end

    always_ff @(posedge clk) begin
        if (reset || bus.clr) begin
            idx_q        <= '0;
            line_valid_q <= 1'b0;
            src_dmem_q   <= 1'b0;
            sel_err_q    <= 1'b0;
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                line_buf[i] <= '0;
            end
        end else begin
            if (do_illegal) begin
                sel_err_q <= 1'b1;
            end
            if (do_capture) begin
                line_buf[idx_q] <= capture_word;
                idx_q           <= idx_q + 1'b1;
                if (at_last) begin
                    line_valid_q <= 1'b1;
                    src_dmem_q   <= (bus.sel_cl == SEL_DMEM);
                end
            end else if (do_replay) begin
                idx_q <= idx_q + 1'b1;
                // last word handed out: the line has been consumed
                if (at_last) begin
                    line_valid_q <= 1'b0;
                end
            end
        end
    end

    assign bus.word_idx   = idx_q;
    assign bus.word_out   = line_buf[idx_q];
    assign bus.full_cl    = at_last;
    assign bus.line_valid = line_valid_q;
    assign bus.src_dmem   = src_dmem_q;
    assign bus.sel_err    = sel_err_q;
endmodule
